// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the 5-stage MIPS pipeline hazard logic.
//               Contents: forwarding-select encodings (these match the input
//               order of the EX operand mux3), the default mult/div latency,
//               the zero-register index and the EX forward-select helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef logic [4:0] reg_idx_t;
  typedef logic [1:0] fwd_sel_t;

  // EX operand mux inputs: 0 = register file, 1 = ResultW, 2 = ALUOutM
  localparam fwd_sel_t FWD_RF = 2'b00;
  localparam fwd_sel_t FWD_W  = 2'b01;
  localparam fwd_sel_t FWD_M  = 2'b10;

  localparam int       MD_LATENCY_DEFAULT = 4;
  localparam reg_idx_t REG_ZERO           = 5'd0;

  // EX-stage forward select for one source operand. M is younger than W,
  // so a match in M must win.
  function automatic fwd_sel_t fwd_sel(input reg_idx_t src,
                                       input logic     reg_write_m,
                                       input reg_idx_t write_reg_m,
                                       input logic     reg_write_w,
                                       input reg_idx_t write_reg_w);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (src != REG_ZERO) begin
      if (reg_write_m && (write_reg_m == src)) begin
        sel = FWD_M;
      end else if (reg_write_w && (write_reg_w == src)) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Signal bundle between the pipeline datapath and the hazard
//               controller. The slave modport is the controller's view, the
//               master modport is the datapath's view.
// Ports       : decode/execute source registers, per-stage destination
//               registers and write enables, load/branch/mult-div flags
//               (datapath -> controller); stall/flush, forward selects and
//               mult/div busy (controller -> datapath).
// Options     : HAZARD_PERF_CNT_EN adds StallCnt and MdStallCnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if;
  import pipe_pkg::*;

  // datapath -> controller
  reg_idx_t RsD, RtD, RsE, RtE;
  reg_idx_t WriteRegE, WriteRegM, WriteRegW;
  logic     RegWriteE, RegWriteM, RegWriteW;
  logic     MemtoRegE, MemtoRegM;
  logic     BranchD;
  logic     MdStartD;
  logic     MdReadD;

  // controller -> datapath
  logic     StallF, StallD, FlushE;
  logic     ForwardAD, ForwardBD;
  fwd_sel_t ForwardAE, ForwardBE;
  logic     MdBusy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCnt;
  logic [31:0] MdStallCnt;
`endif

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MdStartD, MdReadD,
    output StallF, StallD, FlushE, ForwardAD, ForwardBD,
           ForwardAE, ForwardBE, MdBusy
`ifdef HAZARD_PERF_CNT_EN
    , output StallCnt, MdStallCnt
`endif
  );

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, MdStartD, MdReadD,
    input  StallF, StallD, FlushE, ForwardAD, ForwardBD,
           ForwardAE, ForwardBE, MdBusy
`ifdef HAZARD_PERF_CNT_EN
    , input StallCnt, MdStallCnt
`endif
  );

endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_md_scoreboard.sv
// ============================================================================
// Module      : md_scoreboard
// Description : Busy-window tracker for the shared multi-cycle mult/div unit.
//               A countdown is loaded when a mult/div leaves Decode; while it
//               is nonzero, HI/LO are not yet valid and the unit is occupied,
//               so any mult/div or mfhi/mflo in Decode must wait.
// Ports       : clk, rst_n (async, active-low)
//               md_start  - Decode holds mult/multu/div/divu
//               md_read   - Decode holds mfhi/mflo
//               stall     - full pipeline stall (Decode is not advancing)
//               md_busy   - unit occupied
//               md_stall  - this unit's contribution to the pipeline stall
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_scoreboard
  import pipe_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start,
  input  logic md_read,
  input  logic stall,
  output logic md_busy,
  output logic md_stall
);

  localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(MD_LATENCY);

  logic [CNT_W-1:0] r_md_cnt;

  // md_stall depends only on r_md_cnt, never on stall, so feeding the full
  // stall back in here cannot form a combinational loop. A mult that is
  // itself stalled (by any cause) is not issued and must not load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_cnt <= '0;
    end else if (md_start && !stall) begin
      r_md_cnt <= C_LOAD;
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - 1'b1;
    end
  end

  assign md_busy  = (r_md_cnt != '0);
  assign md_stall = md_busy & (md_start | md_read);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard controller for the 5-stage (F/D/E/M/W) MIPS core.
//               Produces EX operand forward selects, Decode branch-compare
//               forwards, and the single stall/flush that covers load-use,
//               branch-operand and mult/div hazards.
// Parameters  : MD_LATENCY - cycles from mult/div issue until HI/LO valid
//               CNT_W      - width of the mult/div busy counter
// Ports       : clk, rst_n (async, active-low), hz (hazard_ctrl_if.slave)
// Options     : HAZARD_PERF_CNT_EN adds free-running 32-bit counters of
//               stall cycles (StallCnt) and mult/div stall cycles
//               (MdStallCnt).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int CNT_W      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  logic w_lwstall;
  logic w_branchstall;
  logic w_md_stall;
  logic w_md_busy;
  logic w_stall;

  // ---------------------------------------------------------------- forwarding
  assign hz.ForwardAE = fwd_sel(hz.RsE, hz.RegWriteM, hz.WriteRegM,
                                hz.RegWriteW, hz.WriteRegW);
  assign hz.ForwardBE = fwd_sel(hz.RtE, hz.RegWriteM, hz.WriteRegM,
                                hz.RegWriteW, hz.WriteRegW);

  // Branch comparator sits in Decode, so only ALUOutM can reach it in time.
  assign hz.ForwardAD = (hz.RsD != REG_ZERO) & hz.RegWriteM &
                        (hz.WriteRegM == hz.RsD);
  assign hz.ForwardBD = (hz.RtD != REG_ZERO) & hz.RegWriteM &
                        (hz.WriteRegM == hz.RtD);

  // -------------------------------------------------------------------- stalls
  // A zero RtE still matches here; the extra bubble is harmless.
  assign w_lwstall = hz.MemtoRegE &
                     ((hz.RtE == hz.RsD) | (hz.RtE == hz.RtD));

  // Operand still being computed in E, or still being loaded in M, cannot
  // be forwarded to the Decode comparator this cycle.
  assign w_branchstall = hz.BranchD &
      ((hz.RegWriteE & ((hz.WriteRegE == hz.RsD) | (hz.WriteRegE == hz.RtD))) |
       (hz.MemtoRegM & ((hz.WriteRegM == hz.RsD) | (hz.WriteRegM == hz.RtD))));

  md_scoreboard #(
    .MD_LATENCY (MD_LATENCY),
    .CNT_W      (CNT_W)
  ) u_md_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_start (hz.MdStartD),
    .md_read  (hz.MdReadD),
    .stall    (w_stall),
    .md_busy  (w_md_busy),
    .md_stall (w_md_stall)
  );

  assign w_stall   = w_lwstall | w_branchstall | w_md_stall;
  assign hz.StallF = w_stall;
  assign hz.StallD = w_stall;
  assign hz.FlushE = w_stall;
  assign hz.MdBusy = w_md_busy;

`ifdef HAZARD_PERF_CNT_EN
  // ------------------------------------------------------ performance counters
  logic [31:0] r_stall_cnt;
  logic [31:0] r_md_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt    <= '0;
      r_md_stall_cnt <= '0;
    end else begin
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_md_stall) begin
        r_md_stall_cnt <= r_md_stall_cnt + 32'd1;
      end
    end
  end

  assign hz.StallCnt   = r_stall_cnt;
  assign hz.MdStallCnt = r_md_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Directed scenarios
//               (forwarding priority, load-use, branch, mult/mfhi, back-to-
//               back mult, overlapping causes, asynchronous reset) followed
//               by random traffic, all compared against a reference model
//               that tracks the mult/div result as an absolute ready cycle.
// Options     : HAZARD_PERF_CNT_EN also checks StallCnt / MdStallCnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

  hazard_ctrl #(
    .MD_LATENCY (LAT),
    .CNT_W      (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: t counts clock edges, the mult/div result is
  // readable once t reaches ready_at.
  int          t        = 0;
  int          ready_at = 0;
  logic [31:0] m_stall_cnt    = 0;
  logic [31:0] m_md_stall_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------- reference model
  function automatic logic [1:0] m_fwd_e(input int src);
    if (src == 0) return 2'd0;
    if (hif.RegWriteM && int'(hif.WriteRegM) == src) return 2'd2;
    if (hif.RegWriteW && int'(hif.WriteRegW) == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit m_fwd_d(input int src);
    return (src != 0) && hif.RegWriteM && (int'(hif.WriteRegM) == src);
  endfunction

  function automatic bit m_busy();
    return t < ready_at;
  endfunction

  function automatic bit m_mdstall();
    return m_busy() && (hif.MdStartD || hif.MdReadD);
  endfunction

  function automatic bit m_stall();
    bit lw, br, srcE, srcM;
    lw   = hif.MemtoRegE && (hif.RtE == hif.RsD || hif.RtE == hif.RtD);
    srcE = hif.RegWriteE && (hif.WriteRegE == hif.RsD || hif.WriteRegE == hif.RtD);
    srcM = hif.MemtoRegM && (hif.WriteRegM == hif.RsD || hif.WriteRegM == hif.RtD);
    br   = hif.BranchD && (srcE || srcM);
    return lw || br || m_mdstall();
  endfunction

  task automatic check_outputs(input string tag);
    bit s;
    s = m_stall();
    chk({tag, ".StallF"},    hif.StallF,    s);
    chk({tag, ".StallD"},    hif.StallD,    s);
    chk({tag, ".FlushE"},    hif.FlushE,    s);
    chk({tag, ".ForwardAE"}, hif.ForwardAE, m_fwd_e(int'(hif.RsE)));
    chk({tag, ".ForwardBE"}, hif.ForwardBE, m_fwd_e(int'(hif.RtE)));
    chk({tag, ".ForwardAD"}, hif.ForwardAD, m_fwd_d(int'(hif.RsD)));
    chk({tag, ".ForwardBD"}, hif.ForwardBD, m_fwd_d(int'(hif.RtD)));
    chk({tag, ".MdBusy"},    hif.MdBusy,    m_busy());
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, ".StallCnt"},   hif.StallCnt,   m_stall_cnt);
    chk({tag, ".MdStallCnt"}, hif.MdStallCnt, m_md_stall_cnt);
`endif
  endtask

  // Check current outputs, advance the model across the coming edge, then
  // return 1 time unit after that edge.
  task automatic step(input string tag);
    bit s;
    #1;
    check_outputs(tag);
    s = m_stall();
    if (hif.MdStartD && !s) ready_at = t + 1 + LAT;
    if (s) m_stall_cnt = m_stall_cnt + 1;
    if (m_mdstall()) m_md_stall_cnt = m_md_stall_cnt + 1;
    @(posedge clk);
    t++;
    #1;
  endtask

  task automatic zero_inputs();
    hif.RsD = '0; hif.RtD = '0; hif.RsE = '0; hif.RtE = '0;
    hif.WriteRegE = '0; hif.WriteRegM = '0; hif.WriteRegW = '0;
    hif.RegWriteE = 1'b0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
    hif.MemtoRegE = 1'b0; hif.MemtoRegM = 1'b0;
    hif.BranchD = 1'b0; hif.MdStartD = 1'b0; hif.MdReadD = 1'b0;
  endtask

  logic [31:0] s0, m0;

  initial begin
    // ---------------------------------------------------------------- reset
    zero_inputs();
    rst_n = 1'b0;
    #1;
    check_outputs("reset");
    chk("reset.MdBusy_const", hif.MdBusy, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    t++;
    #1;

    // ----------------------------------------------------------- forwarding
    hif.RsE = 5'd5; hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd5;
    hif.RegWriteW = 1'b1; hif.WriteRegW = 5'd5;
    #1 chk("fwd_m_prio", hif.ForwardAE, 32'd2);
    step("fwd_m");
    hif.RegWriteM = 1'b0;
    #1 chk("fwd_w", hif.ForwardAE, 32'd1);
    step("fwd_w");
    hif.RsE = 5'd0; hif.RegWriteM = 1'b1;
    #1 chk("fwd_r0", hif.ForwardAE, 32'd0);
    step("fwd_r0");

    // ------------------------------------------------------------- load-use
    zero_inputs();
    hif.MemtoRegE = 1'b1; hif.RegWriteE = 1'b1; hif.WriteRegE = 5'd8;
    hif.RtE = 5'd8; hif.RsD = 5'd8;
    #1 chk("lw_stall", hif.StallF, 32'd1);
    step("lw_stall");
    zero_inputs();
    hif.RsE = 5'd8; hif.RegWriteW = 1'b1; hif.WriteRegW = 5'd8;
    #1 chk("lw_release", hif.StallD, 32'd0);
    chk("lw_fwd_w", hif.ForwardAE, 32'd1);
    step("lw_after");

    // --------------------------------------------------------------- branch
    zero_inputs();
    hif.BranchD = 1'b1; hif.RegWriteE = 1'b1; hif.WriteRegE = 5'd3; hif.RsD = 5'd3;
    #1 chk("br_stall", hif.FlushE, 32'd1);
    step("br_stall");
    hif.RegWriteE = 1'b0; hif.WriteRegE = 5'd0;
    hif.RegWriteM = 1'b1; hif.WriteRegM = 5'd3;
    #1 chk("br_release", hif.StallF, 32'd0);
    chk("br_fwd_ad", hif.ForwardAD, 32'd1);
    step("br_fwd");

    // --------------------------------------------------------- mult, mfhi
    zero_inputs();
    hif.MdStartD = 1'b1;
    step("mult_issue");
    hif.MdStartD = 1'b0; hif.MdReadD = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      #1 chk($sformatf("mfhi_stall%0d", i), hif.StallD, 32'd1);
      chk($sformatf("mfhi_busy%0d", i), hif.MdBusy, 32'd1);
      step("mfhi_wait");
    end
    #1 chk("mfhi_go", hif.StallD, 32'd0);
    chk("mfhi_idle", hif.MdBusy, 32'd0);
    step("mfhi_go");

    // ------------------------------------------------ back-to-back mult
    zero_inputs();
    hif.MdStartD = 1'b1;
    for (int i = 0; i < LAT + 3; i++) step("mult_b2b");

    // ---------------------------------------------------- overlapping causes
    zero_inputs();
    for (int i = 0; i < LAT + 2; i++) step("drain");
    hif.MdStartD = 1'b1;
    step("ovl_issue");
    hif.MdStartD = 1'b0; hif.MdReadD = 1'b1;
    hif.MemtoRegE = 1'b1; hif.RtE = 5'd9; hif.RsD = 5'd9;
    s0 = m_stall_cnt; m0 = m_md_stall_cnt;
    step("ovl0");
    step("ovl1");
    chk("ovl_model_stall_delta", m_stall_cnt - s0, 32'd2);
    chk("ovl_model_md_delta", m_md_stall_cnt - m0, 32'd2);
`ifdef HAZARD_PERF_CNT_EN
    #1 chk("ovl_stallcnt", hif.StallCnt, s0 + 32'd2);
    chk("ovl_mdstallcnt", hif.MdStallCnt, m0 + 32'd2);
`endif

    // ------------------------------------------------- reset mid-countdown
    zero_inputs();
    for (int i = 0; i < LAT + 2; i++) step("drain2");
    hif.MdStartD = 1'b1;
    step("rst_issue");
    hif.MdStartD = 1'b0;
    step("rst_cnt3");
    #1 chk("rst_pre_busy", hif.MdBusy, 32'd1);
    rst_n = 1'b0;
    ready_at = 0; m_stall_cnt = 0; m_md_stall_cnt = 0;
    #1 chk("rst_async_busy", hif.MdBusy, 32'd0);
    check_outputs("rst_async");
    @(posedge clk);
    t++;
    #2 rst_n = 1'b1;
    @(posedge clk);
    t++;
    #1;
    check_outputs("rst_release");

    // ---------------------------------------------------- random traffic
    for (int i = 0; i < 400; i++) begin
      hif.RsD       = 5'($urandom_range(0, 7));
      hif.RtD       = 5'($urandom_range(0, 7));
      hif.RsE       = 5'($urandom_range(0, 7));
      hif.RtE       = 5'($urandom_range(0, 7));
      hif.WriteRegE = 5'($urandom_range(0, 7));
      hif.WriteRegM = 5'($urandom_range(0, 7));
      hif.WriteRegW = 5'($urandom_range(0, 7));
      hif.RegWriteE = 1'($urandom_range(0, 1));
      hif.RegWriteM = 1'($urandom_range(0, 1));
      hif.RegWriteW = 1'($urandom_range(0, 1));
      hif.MemtoRegE = ($urandom_range(0, 3) == 0);
      hif.MemtoRegM = ($urandom_range(0, 3) == 0);
      hif.BranchD   = ($urandom_range(0, 3) == 0);
      hif.MdStartD  = ($urandom_range(0, 7) == 0);
      hif.MdReadD   = ($urandom_range(0, 5) == 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
